// File: rtl/csr_access_arbiter_if.sv
// csr_access_arbiter_if -- bus bundle for the CSR access arbiter.
//
// Carries both requester channels (core, dbg) and the CSR-file side.
//   core_* / dbg_* : valid/ready request handshake, addr/cmd/wdata payload,
//                    rvalid/rdata/illegal response
//   csr_*          : addr/we/wdata toward the CSR file, rdata back (combinational)
// Modports:
//   slave  : arbiter view (requests in, responses and CSR strobes out)
//   master : environment view (requesters plus CSR file model)
interface csr_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              core_valid;
  logic              core_ready;
  logic [ADDR_W-1:0] core_addr;
  logic [1:0]        core_cmd;
  logic [DATA_W-1:0] core_wdata;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_illegal;

  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [1:0]        dbg_cmd;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_illegal;

  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_we;
  logic [DATA_W-1:0] csr_wdata;

  modport slave (
    input  core_valid, core_addr, core_cmd, core_wdata,
    output core_ready, core_rvalid, core_rdata, core_illegal,
    input  dbg_valid, dbg_addr, dbg_cmd, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata, dbg_illegal,
    output csr_addr, csr_we, csr_wdata,
    input  csr_rdata
  );

  modport master (
    output core_valid, core_addr, core_cmd, core_wdata,
    input  core_ready, core_rvalid, core_rdata, core_illegal,
    output dbg_valid, dbg_addr, dbg_cmd, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_illegal,
    input  csr_addr, csr_we, csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter -- read-modify-write CSR access engine shared by a core
// requester and an optional debug requester.
//
// Every access walks IDLE -> READ -> WRITE -> RESP, one cycle each:
//   IDLE  : grant one requester (ready pulse), latch its request
//   READ  : present the address, capture the current CSR value (old_val)
//   WRITE : write new_val back (write/set/clear), unless suppressed
//   RESP  : rvalid pulse to the granted requester with old_val and illegal
// cmd encoding: 00 read, 01 write, 10 set, 11 clear. Non-read commands to
// addr[ADDR_W-1:ADDR_W-2] == 2'b11 are illegal and never write.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csr_access_arbiter_if.slave (core_*, dbg_*, csr_*)
//   busy       : high whenever an access is in flight (not IDLE)
//
// Build option: define CSR_DBG_PORT_EN to enable the debug requester and
// round-robin arbitration. Without it the dbg_* inputs are ignored, dbg_*
// outputs are tied low and the core is always the one granted.
module csr_access_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csr_access_arbiter_if.slave  bus,
  output logic                 busy
);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  req_t              sel_req;
  logic              gnt_dbg_q, gnt_dbg_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic              core_ill_q, core_ill_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_ill_q, dbg_ill_d;

  logic              gnt_core, gnt_dbg;
  logic              illegal;
  logic              wr_en;
  logic [DATA_W-1:0] new_val;

  // ---------------------------------------------------------------------------
  // Arbitration (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
`ifdef CSR_DBG_PORT_EN
  // rr_dbg_q: 1 when dbg wins a tie, i.e. core was granted last.
  // Cleared by reset so the first tie goes to the core.
  logic rr_dbg_q, rr_dbg_d;

  always_comb begin
    gnt_core = 1'b0;
    gnt_dbg  = 1'b0;
    rr_dbg_d = rr_dbg_q;
    if (state_q == IDLE) begin
      if (bus.core_valid && bus.dbg_valid) begin
        gnt_dbg  = rr_dbg_q;
        gnt_core = !rr_dbg_q;
      end else begin
        gnt_core = bus.core_valid;
        gnt_dbg  = bus.dbg_valid;
      end
    end
    if (gnt_core)     rr_dbg_d = 1'b1;
    else if (gnt_dbg) rr_dbg_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_dbg_q <= 1'b0;
    else        rr_dbg_q <= rr_dbg_d;
  end

  always_comb begin
    sel_req = '0;
    if (gnt_dbg) begin
      sel_req.addr  = bus.dbg_addr;
      sel_req.cmd   = bus.dbg_cmd;
      sel_req.wdata = bus.dbg_wdata;
    end else begin
      sel_req.addr  = bus.core_addr;
      sel_req.cmd   = bus.core_cmd;
      sel_req.wdata = bus.core_wdata;
    end
  end
`else
  assign gnt_core = (state_q == IDLE) && bus.core_valid;
  assign gnt_dbg  = 1'b0;

  always_comb begin
    sel_req       = '0;
    sel_req.addr  = bus.core_addr;
    sel_req.cmd   = bus.core_cmd;
    sel_req.wdata = bus.core_wdata;
  end

  logic unused_dbg;
  assign unused_dbg = ^{bus.dbg_valid, bus.dbg_addr, bus.dbg_cmd, bus.dbg_wdata,
                        dbg_rdata_q, dbg_ill_q};
`endif

  // ---------------------------------------------------------------------------
  // Modify step: operand vs. captured CSR value
  // ---------------------------------------------------------------------------
  assign illegal = (req_q.cmd != CMD_READ) && (req_q.addr[ADDR_W-1 -: 2] == 2'b11);

  always_comb begin
    new_val = old_q;
    case (req_q.cmd)
      CMD_WRITE: new_val = req_q.wdata;
      CMD_SET:   new_val = req_q.wdata | old_q;
      CMD_CLEAR: new_val = ~req_q.wdata & old_q;
      default:   new_val = old_q;
    endcase
  end

  // set/clear with a zero operand cannot change the CSR, so skip the write
  // strobe to keep side-effecting CSRs quiet.
  always_comb begin
    wr_en = (state_q == WRITE) && !illegal && (req_q.cmd != CMD_READ);
    if ((req_q.cmd == CMD_SET || req_q.cmd == CMD_CLEAR) && req_q.wdata == '0)
      wr_en = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    gnt_dbg_d    = gnt_dbg_q;
    old_d        = old_q;
    core_rdata_d = core_rdata_q;
    core_ill_d   = core_ill_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_ill_d    = dbg_ill_q;
    case (state_q)
      IDLE: begin
        if (gnt_core || gnt_dbg) begin
          state_d   = READ;
          req_d     = sel_req;
          gnt_dbg_d = gnt_dbg;
        end
      end
      READ: begin
        old_d   = bus.csr_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        // Response registers load here so they are valid during RESP and
        // then simply hold until the next response to the same requester.
        if (gnt_dbg_q) begin
          dbg_rdata_d = old_q;
          dbg_ill_d   = illegal;
        end else begin
          core_rdata_d = old_q;
          core_ill_d   = illegal;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      gnt_dbg_q    <= 1'b0;
      old_q        <= '0;
      core_rdata_q <= '0;
      core_ill_q   <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      gnt_dbg_q    <= gnt_dbg_d;
      old_q        <= old_d;
      core_rdata_q <= core_rdata_d;
      core_ill_q   <= core_ill_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_ill_q    <= dbg_ill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // ready is combinational from valid; gating with rst_n keeps it low while
  // reset is held even if a requester is already presenting valid.
  assign bus.core_ready   = rst_n && gnt_core;
  assign bus.core_rvalid  = (state_q == RESP) && !gnt_dbg_q;
  assign bus.core_rdata   = core_rdata_q;
  assign bus.core_illegal = core_ill_q;

`ifdef CSR_DBG_PORT_EN
  assign bus.dbg_ready    = rst_n && gnt_dbg;
  assign bus.dbg_rvalid   = (state_q == RESP) && gnt_dbg_q;
  assign bus.dbg_rdata    = dbg_rdata_q;
  assign bus.dbg_illegal  = dbg_ill_q;
`else
  assign bus.dbg_ready    = 1'b0;
  assign bus.dbg_rvalid   = 1'b0;
  assign bus.dbg_rdata    = '0;
  assign bus.dbg_illegal  = 1'b0;
`endif

  assign bus.csr_addr  = (state_q == READ || state_q == WRITE) ? req_q.addr : '0;
  assign bus.csr_we    = wr_en;
  assign bus.csr_wdata = (state_q == WRITE) ? new_val : '0;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb_csr_access_arbiter -- self-checking bench for csr_access_arbiter.
// A transaction-level model (accept cycle + fixed offsets, a reference CSR
// array) is compared against the DUT on every falling edge; directed
// sequences add literal expectations; then randomized traffic with
// occasional resets runs against the model.
module tb_csr_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csr_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  csr_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  // Pseudo-random but reproducible power-up CSR contents.
  function automatic logic [31:0] init_val(input logic [11:0] a);
    return 32'h5A5A_0000 ^ ({20'd0, a} * 32'h0001_0193);
  endfunction

  // ---- CSR file seen by the DUT ----
  logic [31:0] csr_file [0:4095];
  bit          csr_wr   [0:4095];
  assign bus.csr_rdata = csr_wr[bus.csr_addr] ? csr_file[bus.csr_addr] : init_val(bus.csr_addr);
  always @(posedge clk)
    if (bus.csr_we) begin
      csr_file[bus.csr_addr] <= bus.csr_wdata;
      csr_wr[bus.csr_addr]   <= 1'b1;
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- Reference model ----
  logic [31:0] ref_mem [0:4095];
  bit          ref_wr  [0:4095];
  int          acc_cyc = -100;   // cycle of the last accept
  int          age;
  bit          gc, gd, prio_dbg;
  bit          m_dbg, m_we, m_ill;
  logic [11:0] m_addr;
  logic [31:0] m_old, m_new, m_op;
  logic [1:0]  m_cmd;
  logic [31:0] h_c_rdata, h_d_rdata;
  bit          h_c_ill, h_d_ill;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst core_ready", bus.core_ready, 0);
      check("rst dbg_ready", bus.dbg_ready, 0);
      check("rst core_rvalid", bus.core_rvalid, 0);
      check("rst dbg_rvalid", bus.dbg_rvalid, 0);
      check("rst core_rdata", bus.core_rdata, 0);
      check("rst core_illegal", bus.core_illegal, 0);
      check("rst dbg_rdata", bus.dbg_rdata, 0);
      check("rst dbg_illegal", bus.dbg_illegal, 0);
      check("rst csr_we", bus.csr_we, 0);
      check("rst csr_addr", bus.csr_addr, 0);
      check("rst csr_wdata", bus.csr_wdata, 0);
      check("rst busy", busy, 0);
      acc_cyc = -100; prio_dbg = 0;
      h_c_rdata = 0; h_d_rdata = 0; h_c_ill = 0; h_d_ill = 0;
    end else begin
      gc = 0; gd = 0;
      if (cyc - acc_cyc >= 4) begin
`ifdef CSR_DBG_PORT_EN
        if (bus.core_valid && bus.dbg_valid) begin gd = prio_dbg; gc = !prio_dbg; end
        else begin gc = bus.core_valid; gd = bus.dbg_valid; end
`else
        gc = bus.core_valid;
`endif
        if (gc || gd) begin
          acc_cyc = cyc; m_dbg = gd; prio_dbg = gc;
          m_addr = gd ? bus.dbg_addr  : bus.core_addr;
          m_cmd  = gd ? bus.dbg_cmd   : bus.core_cmd;
          m_op   = gd ? bus.dbg_wdata : bus.core_wdata;
          m_old  = ref_wr[m_addr] ? ref_mem[m_addr] : init_val(m_addr);
          m_ill  = (m_cmd != 0) && (m_addr >= 12'hC00);
          case (m_cmd)
            2'd1:    m_new = m_op;
            2'd2:    m_new = m_op | m_old;
            2'd3:    m_new = m_old & ~m_op;
            default: m_new = m_old;
          endcase
          m_we = (m_cmd != 0) && !m_ill && !(m_cmd >= 2 && m_op == 0);
        end
      end
      age = cyc - acc_cyc;
      check("core_ready", bus.core_ready, gc);
      check("dbg_ready", bus.dbg_ready, gd);
      check("busy", busy, (age >= 1 && age <= 3));
      check("csr_we", bus.csr_we, (age == 2 && m_we));
      if (age == 2 && m_we) begin
        check("csr_wdata", bus.csr_wdata, m_new);
        ref_mem[m_addr] = m_new;
        ref_wr[m_addr]  = 1'b1;
      end
      if (age == 1 || age == 2)     check("csr_addr", bus.csr_addr, m_addr);
      else if (age == 0 || age >= 4) check("csr_addr idle", bus.csr_addr, 0);
      if (age == 3) begin
        if (m_dbg) begin h_d_rdata = m_old; h_d_ill = m_ill; end
        else       begin h_c_rdata = m_old; h_c_ill = m_ill; end
      end
      check("core_rvalid", bus.core_rvalid, (age == 3 && !m_dbg));
      check("dbg_rvalid", bus.dbg_rvalid, (age == 3 && m_dbg));
      check("core_rdata", bus.core_rdata, h_c_rdata);
      check("core_illegal", bus.core_illegal, h_c_ill);
      check("dbg_rdata", bus.dbg_rdata, h_d_rdata);
      check("dbg_illegal", bus.dbg_illegal, h_d_ill);
    end
  end

  // ---- Directed core access with literal expectations (DUT idle on entry) ----
  task automatic do_core(input string tag, input logic [1:0] cmd, input logic [11:0] addr,
                         input logic [31:0] wd, input bit exp_we, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input bit exp_ill);
    @(posedge clk); #1;
    bus.core_valid = 1; bus.core_cmd = cmd; bus.core_addr = addr; bus.core_wdata = wd;
    @(negedge clk); check({tag, " c0 ready"}, bus.core_ready, 1);
    @(posedge clk); #1; bus.core_valid = 0;
    @(negedge clk); check({tag, " c1 busy"}, busy, 1);
    @(negedge clk); check({tag, " c2 we"}, bus.csr_we, exp_we);
    if (exp_we) check({tag, " c2 wdata"}, bus.csr_wdata, exp_wd);
    @(negedge clk);
    check({tag, " c3 rvalid"}, bus.core_rvalid, 1);
    check({tag, " c3 rdata"}, bus.core_rdata, exp_rd);
    check({tag, " c3 illegal"}, bus.core_illegal, exp_ill);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return 12'h300;
      1: return 12'h301;
      2: return 12'hC00;
      3: return 12'hFFF;
      4: return 12'hBFF;
      5: return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'(1) << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit c_took, d_took;
    bit exp_c, exp_d;
    int rst_cnt;
    bus.core_valid = 1; bus.core_addr = 0; bus.core_cmd = 0; bus.core_wdata = 0;
    bus.dbg_valid  = 1; bus.dbg_addr  = 0; bus.dbg_cmd  = 0; bus.dbg_wdata  = 0;

    // Reset with both requesters already valid: nothing may respond.
    repeat (3) @(negedge clk);
    check("reset ready low", bus.core_ready, 0);
    check("reset busy low", busy, 0);
    @(posedge clk); #1;
    bus.core_valid = 0; bus.dbg_valid = 0; rst_n = 1;
    @(negedge clk);

    do_core("init write", 2'd1, 12'h300, 32'h1, 1, 32'h1, init_val(12'h300), 0);
    do_core("set", 2'd2, 12'h300, 32'h8, 1, 32'h9, 32'h1, 0);
    do_core("clear", 2'd3, 12'h300, 32'h1, 1, 32'h8, 32'h9, 0);
    do_core("set zero", 2'd2, 12'h300, 32'h0, 0, 32'h0, 32'h8, 0);
    do_core("ro write", 2'd1, 12'hC00, 32'h1234, 0, 32'h0, init_val(12'hC00), 1);
    do_core("ro read", 2'd0, 12'hC00, 32'h0, 0, 32'h0, init_val(12'hC00), 0);

    // Reset while the access sits in WRITE: it must vanish without a trace.
    @(posedge clk); #1;
    bus.core_valid = 1; bus.core_cmd = 2'd1; bus.core_addr = 12'h300; bus.core_wdata = 32'hFFFF_FFFF;
    @(negedge clk); check("abort c0 ready", bus.core_ready, 1);
    @(posedge clk); #1; bus.core_valid = 0;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 0;
    @(negedge clk);
    check("abort csr_we", bus.csr_we, 0);
    check("abort busy", busy, 0);
    check("abort rdata", bus.core_rdata, 0);
    @(negedge clk); check("abort rvalid", bus.core_rvalid, 0);
    @(posedge clk); #1; rst_n = 1;
    do_core("after abort", 2'd0, 12'h300, 32'h0, 0, 32'h0, 32'h8, 0);

    // Both requesters held valid from reset.
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    bus.core_valid = 1; bus.core_cmd = 0; bus.core_addr = 12'h010;
    bus.dbg_valid  = 1; bus.dbg_cmd  = 0; bus.dbg_addr  = 12'h020;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
`ifdef CSR_DBG_PORT_EN
      exp_c = (k == 0 || k == 8 || k == 16);
      exp_d = (k == 4 || k == 12);
`else
      exp_c = (k % 4 == 0);
      exp_d = 0;
`endif
      check($sformatf("contend k%0d core_ready", k), bus.core_ready, exp_c);
      check($sformatf("contend k%0d dbg_ready", k), bus.dbg_ready, exp_d);
      if (k == 12) begin @(posedge clk); #1; bus.dbg_valid = 0; end
    end
    @(posedge clk); #1; bus.core_valid = 0;
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional reset.
    rst_cnt = 0;
    repeat (3000) begin
      @(negedge clk);
      c_took = bus.core_valid && bus.core_ready;
      d_took = bus.dbg_valid && bus.dbg_ready;
      @(posedge clk); #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1;
      end else if ($urandom_range(0, 249) == 0) begin
        rst_n = 0; rst_cnt = $urandom_range(1, 2);
      end
      if (c_took) bus.core_valid = 0;
      if (d_took) bus.dbg_valid = 0;
      if (!bus.core_valid && $urandom_range(0, 2) == 0) begin
        bus.core_valid = 1; bus.core_cmd = 2'($urandom);
        bus.core_addr = pick_addr(); bus.core_wdata = pick_data();
      end
      if (!bus.dbg_valid && $urandom_range(0, 2) == 0) begin
        bus.dbg_valid = 1; bus.dbg_cmd = 2'($urandom);
        bus.dbg_addr = pick_addr(); bus.dbg_wdata = pick_data();
      end
    end
    @(posedge clk); #1; rst_n = 1; bus.core_valid = 0; bus.dbg_valid = 0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
